// File: rtl/mips_pkg.sv
// Shared widths, arbiter state encoding and the regfile write payload.
package mips_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned DATA_W = 32;

   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_STALL  = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic              we;
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Mult/div result FIFO: DEPTH entries of {valid, rd, data}, written in push order.
// WB_KILL_STALE_EN adds a kill-by-rd port that clears the valid bit of every stored
// entry whose rd matches a younger pipeline write.
module wb_result_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DW    = DATA_W,
   parameter int unsigned AW    = REG_AW,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [AW-1:0] i_rd,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
`ifdef WB_KILL_STALE_EN
   input  logic          i_kill,
   input  logic [AW-1:0] i_kill_rd,
`endif
   output logic          o_full,
   output logic          o_empty,
   output logic          o_head_valid,
   output logic [AW-1:0] o_head_rd,
   output logic [DW-1:0] o_head_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             r_full;
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] w_valid_nxt;
   logic [AW-1:0]    r_rd   [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic             w_push;
   logic             w_pop;

   // No same-cycle bypass: a full FIFO refuses pushes even when popping.
   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop && (r_count != '0);

   // Occupancy update; simultaneous push and pop leaves it unchanged.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   // Per-entry valid bits: kill first, then retire the head, then mark the new tail.
   always_comb begin
      w_valid_nxt = r_valid;
`ifdef WB_KILL_STALE_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (i_kill && (r_rd[PW'(i)] == i_kill_rd)) begin
            w_valid_nxt[PW'(i)] = 1'b0;
         end
      end
`endif
      if (w_pop) begin
         w_valid_nxt[r_rptr] = 1'b0;
      end
      if (w_push) begin
         w_valid_nxt[r_wptr] = 1'b1;
      end
   end

   // Pointers, occupancy, full flag and valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_valid <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_valid <= w_valid_nxt;
      end
   end

   // Payload storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[r_wptr]   <= i_rd;
         r_data[r_wptr] <= i_data;
      end
   end

   assign o_full       = r_full;
   assign o_empty      = (r_count == '0);
   assign o_head_valid = r_valid[r_rptr];
   assign o_head_rd    = r_rd[r_rptr];
   assign o_head_data  = r_data[r_rptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between the MEM/WB writeback and the mult/div
// result FIFO. A starvation counter forces a one-cycle pipeline stall so queued
// mult/div results always drain. WB_KILL_STALE_EN: granted pipeline writes
// invalidate queued results to the same rd.
module wb_port_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned DW         = DATA_W,
   parameter int unsigned AW         = REG_AW,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wb_regWrite,
   input  logic [AW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   input  logic          md_valid,
   output logic          md_ready,
   input  logic [AW-1:0] md_rd,
   input  logic [DW-1:0] md_data,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          pipe_stall
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   logic [SW-1:0] r_starve_cnt;
   logic [SW-1:0] w_starve_nxt;

   logic          r_rf_we;
   logic [AW-1:0] r_rf_waddr;
   logic [DW-1:0] r_rf_wdata;
   logic          r_pipe_stall;

   logic          w_wb_req;
   logic          w_md_push;
   logic          w_pop;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_head_valid;
   logic [AW-1:0] w_head_rd;
   logic [DW-1:0] w_head_data;
   logic          w_grant_we;
   logic [AW-1:0] w_grant_addr;
   logic [DW-1:0] w_grant_data;

   // A stalled pipeline holds its write; it is not a request until the stall clears.
   assign w_wb_req  = wb_regWrite && (wb_rd != '0) && !r_pipe_stall;
   // rd=0 results complete the handshake but are dropped.
   assign w_md_push = md_valid && (md_rd != '0);
   assign md_ready  = !w_fifo_full;

   wb_result_fifo #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_md_push),
      .i_rd         (md_rd),
      .i_data       (md_data),
      .i_pop        (w_pop),
`ifdef WB_KILL_STALE_EN
      .i_kill       (w_wb_req),
      .i_kill_rd    (wb_rd),
`endif
      .o_full       (w_fifo_full),
      .o_empty      (w_fifo_empty),
      .o_head_valid (w_head_valid),
      .o_head_rd    (w_head_rd),
      .o_head_data  (w_head_data)
   );

   // Grant selection, starvation counting and next state.
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve_cnt;
      w_pop        = 1'b0;
      w_grant_we   = 1'b0;
      w_grant_addr = '0;
      w_grant_data = '0;

      // wb_req is already low in STALL, so the FIFO head wins there unconditionally.
      if (w_wb_req) begin
         w_grant_we   = 1'b1;
         w_grant_addr = wb_rd;
         w_grant_data = wb_data;
      end else if (!w_fifo_empty) begin
         w_pop      = 1'b1;
         w_grant_we = w_head_valid;
         if (w_head_valid) begin
            w_grant_addr = w_head_rd;
            w_grant_data = w_head_data;
         end
      end

      case (r_state)
         ARB_NORMAL: begin
            if (w_fifo_empty || w_pop) begin
               w_starve_nxt = '0;
            end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
               w_starve_nxt = r_starve_cnt + SW'(1);
            end
            if (w_starve_nxt == SW'(STARVE_MAX)) begin
               w_state_nxt = ARB_STALL;
            end
         end
         ARB_STALL: begin
            w_starve_nxt = '0;
            w_state_nxt  = ARB_NORMAL;
         end
         default: begin
            w_starve_nxt = '0;
            w_state_nxt  = ARB_NORMAL;
         end
      endcase
   end

   // FSM state and starvation counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ARB_NORMAL;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Registered write port and stall; the stall flop tracks the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we      <= 1'b0;
         r_rf_waddr   <= '0;
         r_rf_wdata   <= '0;
         r_pipe_stall <= 1'b0;
      end else begin
         r_rf_we      <= w_grant_we;
         r_rf_waddr   <= w_grant_addr;
         r_rf_wdata   <= w_grant_data;
         r_pipe_stall <= (w_state_nxt == ARB_STALL);
      end
   end

   assign rf_we      = r_rf_we;
   assign rf_waddr   = r_rf_waddr;
   assign rf_wdata   = r_rf_wdata;
   assign pipe_stall = r_pipe_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a transaction model predicts each granted write into a
// scoreboard queue; a negedge monitor pops and compares every rf write.
module tb_wb_port_arbiter;
   import mips_pkg::*;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_regWrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pipe_stall;

   int n_checks = 0;
   int n_fail   = 0;

   rf_wr_t sb[$];
   rf_wr_t m_q[$];
   rf_wr_t mon_e;
   int     m_starve;
   bit     m_stall;
   bit     last_stalled;

   wb_port_arbiter #(
      .DW         (32),
      .AW         (5),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_regWrite (wb_regWrite),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .md_valid    (md_valid),
      .md_ready    (md_ready),
      .md_rd       (md_rd),
      .md_data     (md_data),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .pipe_stall  (pipe_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every regfile write must match the oldest predicted write.
   always @(negedge clk) begin
      if (rst_n && rf_we) begin
         if (sb.size() == 0) begin
            check("rf_we_unexpected", 64'(rf_we), 64'(0));
         end else begin
            mon_e = sb.pop_front();
            check("rf_waddr", 64'(rf_waddr), 64'(mon_e.addr));
            check("rf_wdata", 64'(rf_wdata), 64'(mon_e.data));
         end
      end
   end

   task automatic idle_inputs();
      wb_regWrite = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
      md_valid    = 1'b0;
      md_rd       = '0;
      md_data     = '0;
   endtask

   // Asserts reset asynchronously, checks outputs at once, releases after two edges.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      idle_inputs();
      sb.delete();
      m_q.delete();
      m_starve     = 0;
      m_stall      = 1'b0;
      last_stalled = 1'b0;
      #1;
      check({tag, "_rf_we"},      64'(rf_we),      64'(0));
      check({tag, "_rf_waddr"},   64'(rf_waddr),   64'(0));
      check({tag, "_rf_wdata"},   64'(rf_wdata),   64'(0));
      check({tag, "_pipe_stall"}, 64'(pipe_stall), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check({tag, "_md_ready"}, 64'(md_ready), 64'(1));
   endtask

   // Drives one cycle, checks stall/ready against the model, predicts the grant.
   task automatic step(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       output logic acc);
      int     n_before;
      bit     popped;
      rf_wr_t h;
      wb_regWrite = wv;
      wb_rd       = wrd;
      wb_data     = wd;
      md_valid    = mv;
      md_rd       = mrd;
      md_data     = md;
      n_before    = m_q.size();
      check("pipe_stall", 64'(pipe_stall), 64'(m_stall));
      check("md_ready", 64'(md_ready), 64'(n_before < DEPTH));
      popped = 1'b0;
      if (wv && (wrd != 5'd0) && !m_stall) begin
         sb.push_back('{1'b1, wrd, wd});
`ifdef WB_KILL_STALE_EN
         foreach (m_q[i]) begin
            if (m_q[i].addr == wrd) m_q[i].we = 1'b0;
         end
`endif
      end else if (n_before > 0) begin
         h      = m_q.pop_front();
         popped = 1'b1;
         if (h.we) sb.push_back(h);
      end
      last_stalled = m_stall;
      if (m_stall) begin
         m_starve = 0;
         m_stall  = 1'b0;
      end else begin
         if (n_before == 0 || popped) m_starve = 0;
         else if (m_starve < STARVE_MAX) m_starve++;
         m_stall = (m_starve == STARVE_MAX);
      end
      acc = mv && (n_before < DEPTH);
      if (acc && (mrd != 5'd0)) m_q.push_back('{1'b1, mrd, md});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      logic a;
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40 && m_q.size() != 0; i++) idle_step();
      repeat (2) idle_step();
      check(tag, 64'(sb.size()), 64'(0));
   endtask

   logic [4:0]  t4_rd   [3] = '{5'd20, 5'd21, 5'd22};
   logic [31:0] t4_data [3] = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};

   initial begin
      logic       acc;
      logic [4:0] rd;
      int         first;
      int         nstall;
      int         mi;
      int         k;
      int         acc_c;

      idle_inputs();
      rst_n = 1'b1;
      #2;
      apply_reset("por");

      // Idle pipeline, single mult/div result
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD_BEEF, acc);
      check("t2_accept", 64'(acc), 64'(1));
      check("t2_no_write_yet", 64'(rf_we), 64'(0));
      idle_step();
      check("t2_we", 64'(rf_we), 64'(1));
      check("t2_waddr", 64'(rf_waddr), 64'(8));
      check("t2_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
      drain("t2_drain");

      // Busy pipeline starves one queued result until the forced stall
      rd = 5'd3; first = -1; nstall = 0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0 && !last_stalled) rd = rd + 5'd1;
         if (pipe_stall) begin
            if (first < 0) first = c;
            nstall++;
         end
         step(1'b1, rd, 32'h1000_0000 | 32'(rd), c == 0, 5'd9, 32'h0000_0999, acc);
         if (c == 5) begin
            check("t3_stall_we", 64'(rf_we), 64'(1));
            check("t3_stall_waddr", 64'(rf_waddr), 64'(9));
         end
         if (c == 6) check("t3_held_waddr", 64'(rf_waddr), 64'(8));
      end
      check("t3_stall_cycle", 64'(first), 64'(5));
      check("t3_stall_count", 64'(nstall), 64'(1));
      drain("t3_drain");

      // Three back-to-back results into a two-entry FIFO
      rd = 5'd1; mi = 0; acc_c = -1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0 && !last_stalled) rd = (rd == 5'd15) ? 5'd1 : rd + 5'd1;
         if (c == 2) check("t4_full_on_third", 64'(md_ready), 64'(0));
         k = (mi < 3) ? mi : 2;
         step(1'b1, rd, 32'h2000_0000 | 32'(rd), mi < 3, t4_rd[k], t4_data[k], acc);
         if (acc && mi < 3) begin
            if (mi == 2) acc_c = c;
            mi++;
         end
      end
      check("t4_third_accept_cycle", 64'(acc_c), 64'(6));
      drain("t4_drain");

      // rd=0 requests from both sides
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 5'd0, 32'h3333_3333, 1'b1, 5'd0, 32'h4444_4444, acc);
         check("t5_md_accept", 64'(acc), 64'(1));
         check("t5_no_write", 64'(rf_we), 64'(0));
      end
      check("t5_fifo_not_full", 64'(md_ready), 64'(1));
      drain("t5_drain");

      // Pipeline write to the same rd as a queued result
      step(1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd5, 32'h5555_AAAA, acc);
      step(1'b1, 5'd5, 32'h0000_0555, 1'b0, 5'd0, 32'd0, acc);
      check("t6_wb_waddr", 64'(rf_waddr), 64'(5));
      check("t6_wb_wdata", 64'(rf_wdata), 64'(32'h0000_0555));
      idle_step();
`ifdef WB_KILL_STALE_EN
      check("t6_stale_head_we", 64'(rf_we), 64'(0));
`else
      check("t6_head_we", 64'(rf_we), 64'(1));
      check("t6_head_wdata", 64'(rf_wdata), 64'(32'h5555_AAAA));
`endif
      drain("t6_drain");

      // Reset with two results queued behind a busy pipeline
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 5'(10 + c), 32'h6000_0000 | 32'(c), c < 2, 5'(24 + c), 32'h7000_0000 | 32'(c), acc);
      end
      apply_reset("mid_rst");
      for (int c = 0; c < 10; c++) idle_step();
      check("t1_nothing_after_reset", 64'(sb.size()), 64'(0));
      check("t1_md_ready", 64'(md_ready), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
